// File: rtl/multi_wave_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_wave_display_if
//  Description : Sample-capture and pixel-scan signal bundle for the
//                multi-channel wave display. The master side drives samples
//                and pixel coordinates; the slave side returns colour and
//                per-channel swap pulses.
//  Revision    : 1.0  initial release
// ============================================================================
interface multi_wave_display_if #(
    parameter int NCH = 4
);
    logic                  new_sample;
    logic [16*NCH-1:0]     samples;
    logic [NCH-1:0]        ch_enable;
    logic [1:0]            trig_mode;
    logic [10:0]           x;
    logic [9:0]            y;
    logic                  valid;
    logic                  vsync;
    logic [7:0]            r;
    logic [7:0]            g;
    logic [7:0]            b;
    logic [NCH-1:0]        swapped;

    modport master (
        output new_sample, samples, ch_enable, trig_mode, x, y, valid, vsync,
        input  r, g, b, swapped
    );

    modport slave (
        input  new_sample, samples, ch_enable, trig_mode, x, y, valid, vsync,
        output r, g, b, swapped
    );
endinterface
`default_nettype wire

// File: rtl/multi_wave_display.sv
`default_nettype none
// ============================================================================
//  Module      : multi_wave_display
//  Description : NCH-channel triggered waveform capture into double-buffered
//                sample RAMs, rendered as connected line traces with
//                per-channel colours and saturating additive blending.
//                Pixel path latency is fixed at two clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module multi_wave_display #(
    parameter int          NCH          = 4,
    parameter int          ADDR_W       = 9,
    parameter int          X_OFFSET     = 384,
    parameter int          Y_OFFSET     = 384,
    parameter int          TRIG_TIMEOUT = 2048,
    parameter logic [95:0] COLORS       = {24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF}
) (
    input  wire logic            clk,
    input  wire logic            reset,
    multi_wave_display_if.slave  bus
);
    localparam int c_DEPTH = 1 << ADDR_W;
    localparam int c_CNT_W = $clog2(TRIG_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TRIG_TIMEOUT);

    localparam logic [1:0] c_ST_ARMED   = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_DONE    = 2'd2;

    // Window-relative coordinates; negative offsets wrap to large unsigned
    // values and therefore fall outside the window test.
    logic [12:0] w_col;
    logic [11:0] w_row;
    logic        w_in_win;
    assign w_col    = {2'b00, bus.x} - 13'(X_OFFSET);
    assign w_row    = {2'b00, bus.y} - 12'(Y_OFFSET);
    assign w_in_win = (w_col < 13'(c_DEPTH)) && (w_row < 12'd256);

    logic [ADDR_W-1:0] r_s1_col;
    logic [7:0]        r_s1_row;
    logic              r_s1_valid;
    logic              r_s1_in_win;

    // Stage 1: register the window-relative pixel position alongside the RAM read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_col    <= '0;
            r_s1_row    <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_in_win <= 1'b0;
        end else begin
            r_s1_col    <= w_col[ADDR_W-1:0];
            r_s1_row    <= w_row[7:0];
            r_s1_valid  <= bus.valid;
            r_s1_in_win <= w_in_win;
        end
    end

    logic [NCH-1:0] w_lit;

    genvar gc;
    generate
        for (gc = 0; gc < NCH; gc++) begin : g_ch
            logic [7:0]         r_mem [0:2*c_DEPTH-1];
            logic [7:0]         r_rd_data;
            logic [1:0]         r_state;
            logic [ADDR_W-1:0]  r_addr;
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_last_neg;
            logic               r_rd_sel;
            logic               r_has_data;
            logic               r_swapped;
            logic [7:0]         r_px_prev;

            logic [15:0]        w_s;
            logic               w_unused_lo;
            logic               w_en;
            logic               w_cond;
            logic               w_trig;
            logic               w_we;
            logic [ADDR_W-1:0]  w_waddr;
            logic [7:0]         w_v;
            logic [7:0]         w_pv;
            logic [7:0]         w_lo;
            logic [7:0]         w_hi;

            assign w_s         = bus.samples[16*gc +: 16];
            assign w_unused_lo = ^w_s[7:0];
            assign w_en        = bus.ch_enable[gc];

            // Trigger condition from the sign of the previous and current sample
            always_comb begin
                w_cond = 1'b0;
                case (bus.trig_mode)
                    2'b00:   w_cond = 1'b1;
                    2'b01:   w_cond = r_last_neg && !w_s[15];
                    2'b10:   w_cond = !r_last_neg && w_s[15];
                    default: w_cond = 1'b0;
                endcase
            end

            assign w_trig  = w_cond || ((r_cnt == c_TIMEOUT) && (bus.trig_mode != 2'b11));
            assign w_we    = bus.new_sample && w_en &&
                             (((r_state == c_ST_ARMED) && w_trig) || (r_state == c_ST_CAPTURE));
            assign w_waddr = (r_state == c_ST_ARMED) ? '0 : r_addr;

            // Capture writes the back buffer; display reads the front buffer
            always_ff @(posedge clk) begin
                if (w_we)
                    r_mem[{~r_rd_sel, w_waddr}] <= w_s[15:8] ^ 8'h80;
                r_rd_data <= r_mem[{r_rd_sel, w_col[ADDR_W-1:0]}];
            end

            // Capture FSM: arm, fill one buffer, then swap during vsync low
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state    <= c_ST_ARMED;
                    r_addr     <= '0;
                    r_cnt      <= '0;
                    r_last_neg <= 1'b0;
                    r_rd_sel   <= 1'b0;
                    r_has_data <= 1'b0;
                    r_swapped  <= 1'b0;
                end else begin
                    r_swapped <= 1'b0;
                    if (bus.new_sample)
                        r_last_neg <= w_s[15];
                    if (!w_en) begin
                        r_state <= c_ST_ARMED;
                        r_cnt   <= '0;
                    end else begin
                        case (r_state)
                            c_ST_ARMED: begin
                                if (bus.new_sample) begin
                                    if (w_trig) begin
                                        r_addr  <= ADDR_W'(1);
                                        r_state <= c_ST_CAPTURE;
                                        r_cnt   <= '0;
                                    end else if (r_cnt != c_TIMEOUT) begin
                                        r_cnt <= r_cnt + c_CNT_W'(1);
                                    end
                                end
                            end
                            c_ST_CAPTURE: begin
                                if (bus.new_sample) begin
                                    r_addr <= r_addr + ADDR_W'(1);
                                    if (r_addr == {ADDR_W{1'b1}})
                                        r_state <= c_ST_DONE;
                                end
                            end
                            c_ST_DONE: begin
                                if (!bus.vsync) begin
                                    r_rd_sel   <= ~r_rd_sel;
                                    r_has_data <= 1'b1;
                                    r_swapped  <= 1'b1;
                                    r_state    <= c_ST_ARMED;
                                end
                            end
                            default: r_state <= c_ST_ARMED;
                        endcase
                    end
                end
            end

            // Stage 2: light the row span between the previous and current column
            assign w_v  = 8'hFF - r_rd_data;
            assign w_pv = (r_s1_col == '0) ? w_v : r_px_prev;
            assign w_lo = (w_v < w_pv) ? w_v : w_pv;
            assign w_hi = (w_v < w_pv) ? w_pv : w_v;
            assign w_lit[gc] = r_s1_in_win && r_s1_valid && w_en && r_has_data &&
                               (r_s1_row >= w_lo) && (r_s1_row <= w_hi);

            // Remember the last drawn column value so traces stay connected
            always_ff @(posedge clk) begin
                if (reset)
                    r_px_prev <= '0;
                else if (r_s1_valid && r_s1_in_win)
                    r_px_prev <= w_v;
            end

            assign bus.swapped[gc] = r_swapped;
        end
    endgenerate

    logic [9:0] w_sum_r;
    logic [9:0] w_sum_g;
    logic [9:0] w_sum_b;

    // Additive colour blend over all lit channels
    always_comb begin
        w_sum_r = '0;
        w_sum_g = '0;
        w_sum_b = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_lit[i]) begin
                w_sum_r = w_sum_r + 10'(COLORS[24*i+16 +: 8]);
                w_sum_g = w_sum_g + 10'(COLORS[24*i+8  +: 8]);
                w_sum_b = w_sum_b + 10'(COLORS[24*i    +: 8]);
            end
        end
    end

    logic [7:0] r_r;
    logic [7:0] r_g;
    logic [7:0] r_b;

    // Saturate each component at full scale and register the pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end else begin
            r_r <= (w_sum_r > 10'd255) ? 8'hFF : w_sum_r[7:0];
            r_g <= (w_sum_g > 10'd255) ? 8'hFF : w_sum_g[7:0];
            r_b <= (w_sum_b > 10'd255) ? 8'hFF : w_sum_b[7:0];
        end
    end

    assign bus.r = r_r;
    assign bus.g = r_g;
    assign bus.b = r_b;
endmodule
`default_nettype wire

// File: tb/tb_multi_wave_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_wave_display
//  Description : Directed self-checking bench for multi_wave_display with two
//                channels (ch0 white, ch1 red). Expected pixels are queued
//                when a scan is driven and compared when the output appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_wave_display;
    localparam int          NCH = 2;
    localparam int          AW  = 9;
    localparam int          XO  = 384;
    localparam int          YO  = 384;
    localparam int          TMO = 2048;
    localparam logic [95:0] C_COLORS = {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF};
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] BLACK = 24'h000000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    multi_wave_display_if #(.NCH(NCH)) bus ();

    multi_wave_display #(
        .NCH(NCH), .ADDR_W(AW), .X_OFFSET(XO), .Y_OFFSET(YO),
        .TRIG_TIMEOUT(TMO), .COLORS(C_COLORS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic [23:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One new_sample strobe; starts and ends on a falling edge
    task automatic send(input logic [15:0] s0, input logic [15:0] s1);
        bus.samples    = {s1, s0};
        bus.new_sample = 1'b1;
        @(negedge clk);
        bus.new_sample = 1'b0;
    endtask

    // Ramp whose upper byte is k-128, so the stored offset-binary value is k
    task automatic ramp(input int n);
        logic [15:0] v;
        for (int k = 0; k < n; k++) begin
            v = {8'(k - 128), 8'h00};
            send(v, v);
        end
    endtask

    // Two consecutive scan positions; only the second pixel is checked
    task automatic scan2(input int xa0, input int xa1, input int ya,
                         input logic [23:0] exp, input string tag);
        bus.x = 11'(xa0); bus.y = 10'(ya); bus.valid = 1'b1;
        @(negedge clk);
        bus.x = 11'(xa1);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        bus.valid = 1'b0;
        @(negedge clk);
        check(tag_q.pop_front(), {8'h00, bus.r, bus.g, bus.b}, {8'h00, exp_q.pop_front()});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int held_swaps;
        bus.new_sample = 1'b0;
        bus.samples    = '0;
        bus.ch_enable  = 2'b01;
        bus.trig_mode  = 2'b00;
        bus.x          = '0;
        bus.y          = '0;
        bus.valid      = 1'b0;
        bus.vsync      = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_rgb", {8'h00, bus.r, bus.g, bus.b}, 32'h0);
        check("reset_swapped", 32'(bus.swapped), 32'h0);

        // Reset in the middle of a capture
        ramp(300);
        check("midcap_no_swap", 32'(bus.swapped), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midcap_reset_rgb", {8'h00, bus.r, bus.g, bus.b}, 32'h0);
        check("midcap_reset_swapped", 32'(bus.swapped), 32'h0);
        scan2(0, XO + 100, YO + 155, BLACK, "no_data_dark");

        // Free-run ramp capture on ch0
        ramp(512);
        check("ramp_no_early_swap", 32'(bus.swapped), 32'h0);
        @(negedge clk);
        check("ramp_swap", 32'(bus.swapped), 32'h1);
        @(negedge clk);
        check("ramp_swap_one_cycle", 32'(bus.swapped), 32'h0);
        bus.trig_mode = 2'b11;
        scan2(XO + 99,  XO + 100, YO + 155, WHITE, "ramp_lit_155");
        scan2(XO + 99,  XO + 100, YO + 156, WHITE, "ramp_lit_156");
        scan2(XO + 99,  XO + 100, YO + 154, BLACK, "ramp_dark_154");
        scan2(XO + 99,  XO + 100, YO + 157, BLACK, "ramp_dark_157");
        scan2(0,        XO,       YO + 255, WHITE, "col0_lit");
        scan2(0,        XO,       YO + 254, BLACK, "col0_prev_forced");
        scan2(XO + 255, XO + 256, YO + 100, WHITE, "wrap_full_span");
        scan2(0,        XO - 1,   YO + 100, BLACK, "left_of_window");
        scan2(XO + 255, XO + 512, YO + 100, BLACK, "right_of_window");
        scan2(XO + 255, XO + 256, YO + 256, BLACK, "below_window");
        scan2(XO + 255, XO + 256, YO - 1,   BLACK, "above_window");

        // Rising zero-cross trigger
        bus.trig_mode = 2'b01;
        send(16'hFFFB, 16'hFFFB);
        send(16'hFFFF, 16'hFFFF);
        send(16'h0003, 16'h0003);
        repeat (511) send(16'h1000, 16'h1000);
        check("rise_no_early_swap", 32'(bus.swapped), 32'h0);
        @(negedge clk);
        check("rise_swap", 32'(bus.swapped), 32'h1);
        scan2(0,      XO,     YO + 127, WHITE, "rise_addr0_lit");
        scan2(0,      XO,     YO + 128, BLACK, "rise_addr0_not_neg");
        scan2(XO,     XO + 1, YO + 111, WHITE, "rise_col1_lit");
        scan2(XO,     XO + 1, YO + 110, BLACK, "rise_col1_dark");

        // Forced trigger after the timeout with a constant positive input
        repeat (TMO + 511) send(16'd100, 16'd100);
        @(negedge clk);
        check("timeout_not_early", 32'(bus.swapped), 32'h0);
        send(16'd100, 16'd100);
        @(negedge clk);
        check("timeout_swap", 32'(bus.swapped), 32'h1);
        scan2(XO + 99, XO + 100, YO + 127, WHITE, "timeout_data");

        // Completed capture held while vsync is high
        bus.vsync     = 1'b1;
        bus.ch_enable = 2'b11;
        bus.trig_mode = 2'b00;
        ramp(512);
        bus.trig_mode = 2'b11;
        held_swaps = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.swapped != '0) held_swaps++;
        end
        check("gate_no_swap", 32'(held_swaps), 32'h0);
        scan2(XO + 99, XO + 100, YO + 127, WHITE, "gate_display_held");
        bus.vsync = 1'b0;
        @(negedge clk);
        check("gate_swap_both", 32'(bus.swapped), 32'h3);

        // Blending of white and red
        scan2(XO + 99, XO + 100, YO + 155, WHITE, "blend_saturated");
        scan2(XO + 99, XO + 100, YO + 157, BLACK, "blend_dark");
        bus.ch_enable = 2'b10;
        scan2(XO + 99, XO + 100, YO + 155, RED,   "blend_ch1_only");
        bus.ch_enable = 2'b01;
        scan2(XO + 99, XO + 100, YO + 155, WHITE, "blend_ch0_only");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
